// File: rtl/proj_lane_mchk_if.sv
// Per-lane valid/ready/data bundle between the lane FIFOs and the multi-lane checker.
interface proj_lane_mchk_if #(
    parameter int W = 16,
    parameter int N = 4
);
    logic [N-1:0]   vld;
    logic [N*W-1:0] data;
    logic [N-1:0]   rdy;

    modport master (output vld, output data, input  rdy);
    modport slave  (input  vld, input  data, output rdy);
endinterface

// File: rtl/proj_lane_mchk.sv
// N-lane arithmetic-sequence checker: per-lane lock tracking, saturating mismatch
// counters, sticky error flags and an optional periodic ready stall.
module proj_lane_mchk #(
    parameter int W    = 16,
    parameter int N    = 4,
    parameter int EW   = 8,
    parameter int STEP = 1,
    parameter int LOSS = 4,
    parameter int X    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,      // active-low, asynchronous
    input  logic              clr_i,
    proj_lane_mchk_if.slave   bus,
    output logic [N-1:0]      locked_o,
    output logic [N*EW-1:0]   errcntr_o,
    output logic [N-1:0]      errflg_o,
    output logic              anyerr_o
);
    typedef enum logic {SYNC, TRACK} st_e;

    localparam logic [W-1:0]  STEP_W = W'(STEP);
    localparam logic [EW-1:0] LOSS_W = EW'(LOSS);

    logic [N-1:0] rdy_w;

    if (X > 0) begin : g_stall
        logic [X-1:0] stall_q;
        logic [X-1:0] stall_d;
        logic         rdy_q;

        assign stall_d = stall_q + 1'b1;

        // Ready is the registered image of the counter, low on its terminal count.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                stall_q <= '0;
                rdy_q   <= 1'b0;
            end else begin
                stall_q <= stall_d;
                rdy_q   <= (stall_d != {X{1'b1}});
            end
        end

        assign rdy_w = {N{rdy_q}};
    end else begin : g_nostall
        assign rdy_w = '1;
    end

    assign bus.rdy = rdy_w;

    st_e          st_q   [N];
    logic [W-1:0] exp_q  [N];
    logic [EW-1:0] miss_q[N];
    logic [EW-1:0] cnt_q [N];
    logic [W-1:0] din    [N];
    logic [N-1:0] xfer;
    logic [N-1:0] hit;
    logic [N-1:0] locked_q;
    logic [N-1:0] errflg_q;
    logic         anyerr_q;

    always_comb begin
        xfer = bus.vld & rdy_w;
        hit  = '0;
        for (int i = 0; i < N; i++) begin
            din[i] = bus.data[i*W +: W];
            hit[i] = xfer[i] && (st_q[i] == TRACK) && (din[i] != exp_q[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < N; i++) begin
                st_q[i]   <= SYNC;
                exp_q[i]  <= '0;
                miss_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            locked_q <= '0;
            errflg_q <= '0;
            anyerr_q <= 1'b0;
        end else if (clr_i) begin
            for (int i = 0; i < N; i++) begin
                st_q[i]   <= SYNC;
                miss_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            locked_q <= '0;
            errflg_q <= '0;
            anyerr_q <= 1'b0;
        end else begin
            // anyerr tracks the next-state flags so it rises together with errflg.
            anyerr_q <= |(errflg_q | hit);
            for (int i = 0; i < N; i++) begin
                if (xfer[i]) begin
                    exp_q[i] <= din[i] + STEP_W;
                    if (st_q[i] == SYNC) begin
                        st_q[i]     <= TRACK;
                        locked_q[i] <= 1'b1;
                    end else if (!hit[i]) begin
                        miss_q[i] <= '0;
                    end else begin
                        if (cnt_q[i] != {EW{1'b1}})
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        errflg_q[i] <= 1'b1;
                        if ((miss_q[i] + 1'b1) == LOSS_W) begin
                            st_q[i]     <= SYNC;
                            locked_q[i] <= 1'b0;
                            miss_q[i]   <= '0;
                        end else begin
                            miss_q[i] <= miss_q[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign errcntr_o[g*EW +: EW] = cnt_q[g];
    end

    assign locked_o = locked_q;
    assign errflg_o = errflg_q;
    assign anyerr_o = anyerr_q;
endmodule

// File: tb/tb_proj_lane_mchk.sv
// Directed bench for proj_lane_mchk with a per-lane reference model feeding a scoreboard queue.
module tb_proj_lane_mchk;
    localparam int W = 16, N = 4, EW = 8, STEP = 1, LOSS = 4, X = 2;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic [N-1:0]    locked;
    logic [N-1:0]    errflg;
    logic [N*EW-1:0] errcntr;
    logic            anyerr;

    proj_lane_mchk_if #(.W(W), .N(N)) bus();

    proj_lane_mchk #(.W(W), .N(N), .EW(EW), .STEP(STEP), .LOSS(LOSS), .X(X)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (clr),
        .bus       (bus.slave),
        .locked_o  (locked),
        .errcntr_o (errcntr),
        .errflg_o  (errflg),
        .anyerr_o  (anyerr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]    lk;
        logic [N*EW-1:0] ec;
        logic [N-1:0]    ef;
        logic            ae;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int m_trk[N], m_exp[N], m_miss[N], m_cnt[N], m_flg[N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_trk[i] = 0; m_exp[i] = 0; m_miss[i] = 0; m_cnt[i] = 0; m_flg[i] = 0;
        end
    endtask

    task automatic model_xfer(input int i, input int d);
        int nxt;
        nxt = (d + STEP) % (1 << W);
        if (m_trk[i] == 0) begin
            m_trk[i] = 1;
        end else if (d == m_exp[i]) begin
            m_miss[i] = 0;
        end else begin
            if (m_cnt[i] < (1 << EW) - 1) m_cnt[i]++;
            m_flg[i] = 1;
            m_miss[i]++;
            if (m_miss[i] == LOSS) begin
                m_trk[i]  = 0;
                m_miss[i] = 0;
            end
        end
        m_exp[i] = nxt;
    endtask

    task automatic push_expect();
        exp_t e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            e.lk[i]          = (m_trk[i] != 0);
            e.ec[i*EW +: EW] = EW'(m_cnt[i]);
            e.ef[i]          = (m_flg[i] != 0);
        end
        e.ae = |e.ef;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk("locked",  64'(locked),  64'(e.lk));
            chk("errcntr", 64'(errcntr), 64'(e.ec));
            chk("errflg",  64'(errflg),  64'(e.ef));
            chk("anyerr",  64'(anyerr),  64'(e.ae));
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int d0, input int d1, input int d2, input int d3);
        pk = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endfunction

    // Called at a negedge; holds vld through stall cycles until the word is taken.
    task automatic send(input logic [N-1:0] v, input logic [N*W-1:0] d);
        int k;
        bus.vld  = v;
        bus.data = d;
        k = 0;
        while (bus.rdy[0] !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (k == 8) chk("rdy_timeout", 64'(bus.rdy[0]), 64'd1);
        for (int i = 0; i < N; i++)
            if (v[i]) model_xfer(i, int'(d[i*W +: W]));
        push_expect();
        @(posedge clk);
        @(negedge clk);
        bus.vld = '0;
        check_out();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lows;
        rst = 1'b0;
        clr = 1'b0;
        bus.vld  = '0;
        bus.data = '0;
        model_reset();

        #12;
        chk("rst_locked",  64'(locked),  64'd0);
        chk("rst_errcntr", 64'(errcntr), 64'd0);
        chk("rst_errflg",  64'(errflg),  64'd0);
        chk("rst_anyerr",  64'(anyerr),  64'd0);
        chk("rst_rdy",     64'(bus.rdy), 64'd0);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        lows = 0;
        for (int c = 0; c < 16; c++) begin
            if (bus.rdy == '0) lows++;
            chk("rdy_uniform", 64'((bus.rdy == '0) || (bus.rdy == '1)), 64'd1);
            @(negedge clk);
        end
        chk("rdy_lows_per_16", 64'(lows), 64'd4);

        for (int k = 0; k <= 20; k++) send(4'hF, pk(k, k, k, k));
        chk("seq_locked", 64'(locked),  64'hF);
        chk("seq_err",    64'(errcntr), 64'd0);

        send(4'b0100, pk(0, 0, 21, 0));
        send(4'b0100, pk(0, 0, 22, 0));
        send(4'b0100, pk(0, 0, 25, 0));
        send(4'b0100, pk(0, 0, 26, 0));
        send(4'b0100, pk(0, 0, 27, 0));
        chk("l2_cnt",  64'(errcntr[2*EW +: EW]), 64'd1);
        chk("l2_lock", 64'(locked[2]),           64'd1);
        chk("l2_flg",  64'(errflg),              64'b0100);

        send(4'b0001, pk(21, 0, 0, 0));
        send(4'b0001, pk(22, 0, 0, 0));
        send(4'b0001, pk(28, 0, 0, 0));
        send(4'b0001, pk(24, 0, 0, 0));
        send(4'b0001, pk(30, 0, 0, 0));
        send(4'b0001, pk(23, 0, 0, 0));
        chk("l0_cnt_loss",  64'(errcntr[EW-1:0]), 64'd4);
        chk("l0_lock_loss", 64'(locked[0]),       64'd0);
        send(4'b0001, pk(100, 0, 0, 0));
        chk("l0_relock",     64'(locked[0]),       64'd1);
        chk("l0_relock_cnt", 64'(errcntr[EW-1:0]), 64'd4);
        send(4'b0001, pk(101, 0, 0, 0));

        bus.vld  = 4'hF;
        bus.data = pk(500, 500, 500, 500);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        bus.vld = '0;
        model_reset();
        push_expect();
        check_out();
        chk("clr_anyerr", 64'(anyerr), 64'd0);

        send(4'hF, pk('hFFFE, 'hFFFE, 'hFFFE, 'hFFFE));
        send(4'hF, pk('hFFFF, 'hFFFF, 'hFFFF, 'hFFFF));
        send(4'hF, pk(0, 0, 0, 0));
        send(4'hF, pk(1, 1, 1, 1));
        chk("wrap_err",  64'(errcntr), 64'd0);
        chk("wrap_lock", 64'(locked),  64'hF);

        for (int k = 0; k < 400; k++) send(4'b0010, pk(0, (k % 2) ? 50 : 100, 0, 0));
        chk("l1_sat", 64'(errcntr[EW +: EW]), 64'd255);

        send(4'hF, pk(200, 200, 200, 200));
        bus.vld  = 4'hF;
        bus.data = pk(9, 9, 9, 9);
        #2 rst = 1'b0;
        #1;
        chk("arst_locked",  64'(locked),  64'd0);
        chk("arst_errcntr", 64'(errcntr), 64'd0);
        chk("arst_errflg",  64'(errflg),  64'd0);
        chk("arst_anyerr",  64'(anyerr),  64'd0);
        chk("arst_rdy",     64'(bus.rdy), 64'd0);
        model_reset();
        bus.vld = '0;
        @(negedge clk);
        rst = 1'b1;
        send(4'hF, pk(7, 7, 7, 7));
        send(4'hF, pk(8, 8, 8, 8));
        chk("post_rst_err",  64'(errcntr), 64'd0);
        chk("post_rst_lock", 64'(locked),  64'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
